// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler
//
// Video timing and configuration scheduler for the VGA pattern generator.
// The block runs the pixel and line counters and decodes sync and blanking
// from them. It owns the pattern-configuration byte. A host write is held in
// a pending slot and moved into cfg_active only at the start of vertical
// blanking, so every visible frame uses one configuration. The block also
// keeps the per-frame animation state (frame counter, phase accumulator).
//
// Ports:
//   clk          pixel clock (25 MHz with the default timing)
//   rst          asynchronous, active-high reset
//   cfg_wr       single-cycle write strobe
//   cfg_data     configuration byte, sampled with cfg_wr
//   cfg_ack      one-cycle acknowledge, the cycle after a captured write
//   cfg_busy     a written byte is pending and not yet applied
//   cfg_active   configuration in force for the current frame
//   hpos, vpos   pixel / line counters
//   hsync, vsync active-low sync pulses, aligned with hpos/vpos
//   display_on   visible-region flag, aligned with hpos/vpos
//   frame_start  one-cycle pulse on the first pixel of each new frame
//   frame_count  frames since reset, wraps at 256
//   anim_phase   phase accumulator, += cfg_active[2:0] per frame unless paused
//
// The timing parameters default to 640x480 at 60 Hz (800x525 total).
module vga_frame_scheduler #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_data,
    output logic       cfg_ack,
    output logic       cfg_busy,
    output logic [7:0] cfg_active,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       frame_start,
    output logic [7:0] frame_count,
    output logic [7:0] anim_phase
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
    localparam logic [9:0] V_APPLY_LINE = 10'(V_ACTIVE - 1);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        StIdle,
        StPending
    } cfg_state_e;

    cfg_state_e state_q, state_d;

    logic [9:0] hpos_q, hpos_d;
    logic [9:0] vpos_q, vpos_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] cfg_active_q, cfg_active_d;
    logic       cfg_ack_q, cfg_ack_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic [7:0] anim_phase_q, anim_phase_d;

    logic line_end;
    logic apply_edge;
    logic frame_end;

    // Edge classification, all taken from the counter values before the edge.
    // apply_edge is (last pixel, last visible line) -> (0, first blank line).
    assign line_end   = (hpos_q == H_LAST);
    assign apply_edge = line_end && (vpos_q == V_APPLY_LINE);
    assign frame_end  = line_end && (vpos_q == V_LAST);

    // Pixel and line counters.
    always_comb begin
        hpos_d = hpos_q + 10'd1;
        vpos_d = vpos_q;
        if (line_end) begin
            hpos_d = 10'd0;
            vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    // Config FSM. The apply consumes the pending byte from before the edge;
    // a write on the same edge is evaluated afterwards, so it re-arms PENDING
    // with the new byte and is applied at the following vblank.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        cfg_active_d = cfg_active_q;
        cfg_ack_d    = cfg_wr;

        if (apply_edge && (state_q == StPending)) begin
            cfg_active_d = pending_q;
            state_d      = StIdle;
        end

        if (cfg_wr) begin
            pending_d = cfg_data;
            state_d   = StPending;
        end
    end

    // Per-frame animation state. The apply edge never coincides with the
    // frame wrap, so cfg_active_q here is the config of the frame just shown.
    always_comb begin
        frame_start_d = frame_end;
        frame_count_d = frame_count_q;
        anim_phase_d  = anim_phase_q;
        if (frame_end) begin
            frame_count_d = frame_count_q + 8'd1;
            if (!cfg_active_q[7]) begin
                anim_phase_d = anim_phase_q + {5'd0, cfg_active_q[2:0]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            state_q       <= StIdle;
            pending_q     <= 8'h00;
            cfg_active_q  <= 8'h00;
            cfg_ack_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= 8'd0;
            anim_phase_q  <= 8'd0;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            state_q       <= state_d;
            pending_q     <= pending_d;
            cfg_active_q  <= cfg_active_d;
            cfg_ack_q     <= cfg_ack_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
            anim_phase_q  <= anim_phase_d;
        end
    end

    // Sync and blanking are plain decodes of the counter registers, so they
    // line up with hpos/vpos with no extra pipeline stage.
    assign hsync      = !((hpos_q >= H_SYNC_FIRST) && (hpos_q <= H_SYNC_LAST));
    assign vsync      = !((vpos_q >= V_SYNC_FIRST) && (vpos_q <= V_SYNC_LAST));
    assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign cfg_ack     = cfg_ack_q;
    assign cfg_busy    = (state_q == StPending);
    assign cfg_active  = cfg_active_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign anim_phase  = anim_phase_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler, built with a shrunken video timing so many
// whole frames fit in a short run. The reference model tracks elapsed cycles
// since reset and derives every output from that count arithmetically.
module tb_vga_frame_scheduler;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;  // 15
    localparam int VT = VA + VF + VS + VB;  // 10
    localparam int FRAME = HT * VT;         // 150

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_wr = 1'b0;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_ack, cfg_busy, hsync, vsync, display_on, frame_start;
    logic [7:0] cfg_active, frame_count, anim_phase;
    logic [9:0] hpos, vpos;

    int n_tests = 0;
    int n_fail  = 0;

    vga_frame_scheduler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_wr     (cfg_wr),
        .cfg_data   (cfg_data),
        .cfg_ack    (cfg_ack),
        .cfg_busy   (cfg_busy),
        .cfg_active (cfg_active),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .frame_start(frame_start),
        .frame_count(frame_count),
        .anim_phase (anim_phase)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, wanted finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)",
                         name, $time, act, act, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int       m_t;       // cycles elapsed since reset release
    bit       m_busy;
    bit       m_ack;
    bit [7:0] m_pend;
    bit [7:0] m_active;
    int       m_phase;

    function automatic int cur_h();
        return m_t % HT;
    endfunction

    function automatic int cur_v();
        return (m_t / HT) % VT;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_busy = 0; m_ack = 0; m_pend = 0; m_active = 0; m_phase = 0;
        end else begin
            // Frame wrap: animation uses the config of the frame just shown.
            if ((m_t + 1) % FRAME == 0 && !m_active[7])
                m_phase = (m_phase + int'(m_active[2:0])) % 256;
            // Start of vblank: commit whatever was pending before this edge.
            if (cur_h() == HT - 1 && cur_v() == VA - 1 && m_busy) begin
                m_active = m_pend;
                m_busy   = 0;
            end
            if (cfg_wr) begin
                m_pend = cfg_data;
                m_busy = 1;
            end
            m_ack = cfg_wr;
            m_t++;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        int h, v;
        h = cur_h();
        v = cur_v();
        check("hpos", int'(hpos), h);
        check("vpos", int'(vpos), v);
        check("hsync", int'(hsync), (h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
        check("vsync", int'(vsync), (v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
        check("display_on", int'(display_on), (h < HA && v < VA) ? 1 : 0);
        check("frame_start", int'(frame_start), (m_t > 0 && m_t % FRAME == 0) ? 1 : 0);
        check("frame_count", int'(frame_count), (m_t / FRAME) % 256);
        check("cfg_ack", int'(cfg_ack), int'(m_ack));
        check("cfg_busy", int'(cfg_busy), int'(m_busy));
        check("cfg_active", int'(cfg_active), int'(m_active));
        check("anim_phase", int'(anim_phase), m_phase);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_pos(input int h, input int v);
        bit ok = 0;
        for (int i = 0; i <= FRAME; i++) begin
            @(negedge clk);
            if (cur_h() == h && cur_v() == v) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("wait_pos_timeout", 0, 1);
    endtask

    // Write strobe on the edge leaving position (h,v); returns one cycle later.
    task automatic write_at(input int h, input int v, input logic [7:0] d);
        wait_pos(h, v);
        cfg_wr   = 1'b1;
        cfg_data = d;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_hpos", int'(hpos), 0);
        check("rst_vpos", int'(vpos), 0);
        check("rst_sync", int'({hsync, vsync, display_on}), 7);
        check("rst_flags", int'({frame_start, cfg_ack, cfg_busy}), 0);
        check("rst_cfg_active", int'(cfg_active), 0);
        check("rst_frame_count", int'(frame_count), 0);
        check("rst_anim_phase", int'(anim_phase), 0);
        repeat (cycles) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int first_fs;
        do_reset(3);

        // First frame_start exactly one frame period after release.
        first_fs = -1;
        for (int i = 1; i <= FRAME + 5; i++) begin
            @(negedge clk);
            if (frame_start) begin
                first_fs = i;
                break;
            end
        end
        check("first_frame_start_cycle", first_fs, 150);

        // Single write, applied at vblank, then phase accumulates 5 per frame.
        write_at(3, 1, 8'h05);
        check("ack_after_write", int'(cfg_ack), 1);
        check("busy_after_write", int'(cfg_busy), 1);
        @(negedge clk);
        check("ack_one_cycle", int'(cfg_ack), 0);
        wait_pos(HT - 1, VA - 1);
        check("active_before_apply", int'(cfg_active), 8'h00);
        @(negedge clk);
        check("active_after_apply", int'(cfg_active), 8'h05);
        check("busy_after_apply", int'(cfg_busy), 0);
        wait_pos(0, 0);
        check("phase_after_1", int'(anim_phase), 5);
        wait_pos(0, 0);
        check("phase_after_2", int'(anim_phase), 10);

        // Two writes in one frame: last wins, pause bit freezes the phase.
        write_at(2, 2, 8'h03);
        check("ack_w1", int'(cfg_ack), 1);
        write_at(5, 3, 8'h84);
        check("ack_w2", int'(cfg_ack), 1);
        wait_pos(0, VA);
        check("active_last_wins", int'(cfg_active), 8'h84);
        wait_pos(0, 0);
        wait_pos(0, 0);
        check("phase_paused", int'(anim_phase), 10);
        check("count_runs_paused", int'(frame_count), 5);

        // Write landing exactly on the apply edge with 0x01 already pending.
        write_at(1, 1, 8'h01);
        write_at(HT - 1, VA - 1, 8'h02);
        check("apply_edge_active", int'(cfg_active), 8'h01);
        check("apply_edge_busy", int'(cfg_busy), 1);
        check("apply_edge_ack", int'(cfg_ack), 1);
        wait_pos(0, VA);
        check("apply_edge_next", int'(cfg_active), 8'h02);
        check("apply_edge_next_busy", int'(cfg_busy), 0);

        // Reset with a write pending: it must never be applied.
        write_at(1, 1, 8'h44);
        wait_pos(4, 3);
        do_reset(2);
        wait_pos(1, VA);
        check("pending_discarded", int'(cfg_active), 8'h00);
        check("pending_discarded_busy", int'(cfg_busy), 0);

        // 257 frames with config 0x07: count and phase wrap modulo 256.
        do_reset(2);
        write_at(1, 1, 8'h07);
        for (int n = 1; n <= 257; n++) begin
            wait_pos(0, 0);
            if (n == 255 || n == 256 || n == 257 || n % 37 == 0) begin
                check("wrap_frame_count", int'(frame_count), n % 256);
                check("wrap_anim_phase", int'(anim_phase), (7 * n) % 256);
            end
        end

        // Random traffic with one reset at a random point.
        for (int c = 0; c < 6 * FRAME; c++) begin
            @(negedge clk);
            cfg_wr   = ($urandom_range(0, 24) == 0);
            cfg_data = 8'($urandom);
            if (c == 3 * FRAME + 17) begin
                cfg_wr = 1'b0;
                do_reset(1);
            end
        end
        @(negedge clk);
        cfg_wr = 1'b0;
        repeat (2 * FRAME) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
